// File: rtl/rojo_updt_sync_pkg.sv
// Shared definitions for the Rojobot update synchronizer: state encoding,
// default BotInfo width and the overrun counter saturation value.
package rojo_updt_sync_pkg;

  localparam int         INFO_W_DEF = 32;
  localparam logic [7:0] MISSED_SAT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACKW = 2'd2
  } state_t;

endpackage

// File: rtl/rojo_updt_sync_if.sv
// Software-facing side of the Rojobot update bridge. The peripheral register
// logic (master) drives the acknowledge level and reads back the pending
// flag, the BotInfo snapshot, the interrupt pulse and the overrun count.
interface rojo_updt_sync_if #(
  parameter int INFO_W = rojo_updt_sync_pkg::INFO_W_DEF
);
  logic              IO_INT_ACK;
  logic              IO_BotUpdt_Sync;
  logic [INFO_W-1:0] IO_BotInfo;
  logic              irq_pulse;
  logic [7:0]        missed_cnt;

  modport master (
    output IO_INT_ACK,
    input  IO_BotUpdt_Sync,
    input  IO_BotInfo,
    input  irq_pulse,
    input  missed_cnt
  );

  modport slave (
    input  IO_INT_ACK,
    output IO_BotUpdt_Sync,
    output IO_BotInfo,
    output irq_pulse,
    output missed_cnt
  );
endinterface

// File: rtl/rojo_updt_sync_sync_edge.sv
// rojo_sync_edge: multi-flop synchronizer for a strobe from another clock
// domain followed by a rising-edge detector. A strobe held high yields a
// single rise. SYNC_STAGES must be 2 or more.
module rojo_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Shift the asynchronous strobe through the chain and remember the last stage.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/rojo_updt_sync.sv
// rojo_updt_sync: brings the Rojobot update strobe and BotInfo word into the
// HCLK domain, keeps the software pending flag, raises a one-cycle interrupt
// whenever the flag sets, and runs the IO_INT_ACK handshake. An update that
// arrives while software is still acknowledging is held in a deferred bit and
// delivered once the ack level returns to 0.
// Build option: define ROJO_MISSED_CNT_EN to implement the saturating count
// of overwritten updates; otherwise missed_cnt reads as 0.
module rojo_updt_sync
  import rojo_updt_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int INFO_W      = INFO_W_DEF
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              bot_updt_raw_i,
  input  logic [INFO_W-1:0] bot_info_raw_i,
  rojo_updt_sync_if.slave   bus
);

  logic              rise;
  logic              ack;
  state_t            state_q, state_d;
  logic              defer_q, defer_d;
  logic              irq_q, irq_d;
  logic [INFO_W-1:0] info_q;
  logic              flag;

  assign ack = bus.IO_INT_ACK;

  rojo_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .async_i (bot_updt_raw_i),
    .rise_o  (rise)
  );

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and deferred-update bookkeeping.
  always_comb begin
    state_d = state_q;
    defer_d = defer_q;
    case (state_q)
      IDLE: begin
        if (rise) state_d = PEND;
      end
      PEND: begin
        // An update landing on the ack edge is parked, not lost.
        if (ack) begin
          state_d = ACKW;
          defer_d = rise;
        end
      end
      ACKW: begin
        if (!ack) begin
          state_d = (defer_q || rise) ? PEND : IDLE;
          defer_d = 1'b0;
        end else if (rise) begin
          defer_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        defer_d = 1'b0;
      end
    endcase
  end

  // Pending flag seen by software.
  always_comb begin
    flag = 1'b0;
    if (state_q == PEND) flag = 1'b1;
  end

  // Interrupt fires on every entry into PEND, never while already pending.
  assign irq_d = (state_d == PEND) && (state_q != PEND);

  // Deferred bit, interrupt pulse and the BotInfo snapshot taken on each rise.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      defer_q <= 1'b0;
      irq_q   <= 1'b0;
      info_q  <= '0;
    end else begin
      defer_q <= defer_d;
      irq_q   <= irq_d;
      if (rise) info_q <= bot_info_raw_i;
    end
  end

`ifdef ROJO_MISSED_CNT_EN
  logic       miss_inc;
  logic [7:0] missed_q;

  // An update is lost when it overwrites one software has not yet taken.
  always_comb begin
    miss_inc = 1'b0;
    if (rise && (((state_q == PEND) && !ack) || ((state_q == ACKW) && defer_q)))
      miss_inc = 1'b1;
  end

  // Saturating overrun counter, cleared only by reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      missed_q <= 8'h00;
    end else if (miss_inc && (missed_q != MISSED_SAT)) begin
      missed_q <= missed_q + 8'd1;
    end
  end

  assign bus.missed_cnt = missed_q;
`else
  assign bus.missed_cnt = 8'h00;
`endif

  assign bus.IO_BotUpdt_Sync = flag;
  assign bus.IO_BotInfo      = info_q;
  assign bus.irq_pulse       = irq_q;

endmodule
